usb_tx_serializer: RTL
======================

# usb_tx_serializer

Transmit-side serializer for the USB full-speed link. It accepts packet bytes over a valid/ready handshake and shifts each byte out LSB-first. It inserts a stuff bit after every six consecutive 1s, NRZI-encodes the result onto d_plus/d_minus, and closes each packet with EOP. It sits between the TX packet-assembly logic and the bus pads, mirroring the receive path's destuffing shift register.

## Interface
- CLKS_PER_BIT, 8, clock cycles per bus bit period (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  packet byte, LSB transmitted first
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  byte is final byte of packet
- tx_ready  out  1  holding register empty; transfer when tx_valid & tx_ready at a rising edge
- d_plus  out  1  bus D+ (registered)
- d_minus  out  1  bus D- (registered)
- tx_active  out  1  high from first bit of a packet through end of EOP
- tx_err  out  1  one-cycle pulse on underrun

## Operation
- Line states: J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0).
- Reset values: J on the line, tx_ready=1, tx_active=0, tx_err=0, state IDLE, holding register empty, ones counter 0. Reset mid-packet aborts immediately; no EOP is sent.
- Holding register: one byte plus last flag; tx_ready = ~hold_full. The shifter takes the holding byte when its current byte's bit 7 period expires, or on leaving IDLE.
- FSM states:
  - IDLE: wait for hold_full → SHIFT. Load the shifter, clear the ones counter, assert tx_active.
  - SHIFT: drive one data bit per bit period. NRZI: a 0 toggles J/K; a 1 holds the line. After the bit period: if six consecutive 1s have been sent → STUFF. Else if bit 7 of the last byte has been sent → EOP_SE0. Else if bit 7 has been sent and the holding register is empty → pulse tx_err, go to EOP_SE0. Else continue to the next bit or byte.
  - STUFF: one bit period of toggle, which is an encoded 0. Clear the ones counter. The bit index does not advance. Exit follows the same end-of-byte rules as SHIFT.
  - EOP_SE0: drive SE0 for 2 bit periods → EOP_J.
  - EOP_J: drive J for 1 bit period → IDLE, deassert tx_active.
- Ones counter:
  - Counts data 1s and clears on any 0 or stuff bit.
  - Carries across byte boundaries.
  - A stuff bit is still inserted when the sixth 1 is the packet's final bit, before EOP.
- NRZI reference level at packet start is the idle J.

## Timing
- Handshake at edge k: the byte is captured at k. At edge k+1 the line presents bit 0's level and tx_active rises (packet start from IDLE).
- Each bit, stuff bit and EOP segment lasts exactly CLKS_PER_BIT cycles. The bit timer restarts on every line update.
- During a packet, tx_ready rises the cycle after the shifter consumes the holding byte. A new byte is accepted at any time during the current byte.
- Packet length in bit periods = 8·bytes + stuff bits + 3 (EOP).
- A byte arriving during EOP is held and starts a new packet one cycle after EOP_J ends.

## Configuration
- USB_TX_SYNC_EN defined: on leaving IDLE the block first transmits SYNC 8'h80 (LSB-first: seven 0s, then a 1) and then the holding byte. The SYNC bits count toward the ones counter.
- USB_TX_SYNC_EN undefined: no SYNC is generated; the first byte supplied upstream must be 8'h80.

## Structure
- Package usb_tx_pkg holds:
  - the state enum;
  - SYNC_BYTE = 8'h80;
  - STUFF_LIMIT = 6;
  - line-state constants LINE_J, LINE_K, LINE_SE0 as {d_plus, d_minus}.
- Sub-module usb_nrzi_encoder (registered d_plus/d_minus; inputs bit, bit_strobe, force_se0, force_j).
- Bit timer and FSM live in the top module.

## Test plan
- Reset, then idle 50 cycles → d_plus=1, d_minus=0, tx_ready=1, tx_active=0 throughout.
- Single byte 8'h00, tx_last=1 (SYNC off) → line K,J,K,J,K,J,K,J, then SE0,SE0,J; each segment 8 cycles; tx_active high for 88 cycles.
- Bytes 8'hFF, 8'hFF (last) → stuff after data bits 6 and 12. Line: J×6, K (stuff), K×6, J (stuff), J×4, then EOP. That is 18 bit periods before SE0.
- Byte 8'h3F, tx_last=1 → six 1s then a stuff bit, then bits 6–7 (0,0). Confirms stuffing at an in-byte boundary; 9 data bit periods.
- Underrun: byte 8'hA5 with tx_last=0, no second byte → tx_err pulses once at end of bit 7, then EOP follows; tx_active falls after EOP_J.
- With USB_TX_SYNC_EN: byte 8'h00 last → line K,J,K,J,K,J,K,K (SYNC), then 8 toggling bits, then EOP.
- Reset during bit 3 → line returns to J next cycle; tx_active=0 and tx_ready=1.

Source files
------------

// File: rtl/usb_tx_serializer_pkg.sv
// ----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB full-speed transmit serializer.
//   tx_state_t  : serializer FSM states
//   SYNC_BYTE   : SYNC pattern sent ahead of packet data when SYNC insertion
//                 is built in (USB_TX_SYNC_EN)
//   STUFF_LIMIT : run of consecutive 1s that forces a stuff bit
//   LINE_*      : bus line states encoded as {d_plus, d_minus}
// ----------------------------------------------------------------------------
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// usb_tx_serializer_if
// Byte handshake between the TX packet-assembly logic and the serializer.
//   tx_data  : packet byte, LSB sent first
//   tx_valid : tx_data/tx_last valid
//   tx_last  : byte is the final byte of the packet
//   tx_ready : serializer holding register empty
// A byte transfers on a rising edge where tx_valid & tx_ready.
// modport master : upstream packet source
// modport slave  : serializer
// ----------------------------------------------------------------------------
interface usb_tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/usb_tx_serializer_nrzi_encoder.sv
// ----------------------------------------------------------------------------
// usb_nrzi_encoder
// Registered NRZI line driver. On each bit_strobe the line is updated:
//   force_se0 : drive SE0 (NRZI level is kept)
//   force_j   : drive J and re-seed the NRZI level to J
//   otherwise : tx_bit = 0 toggles J/K, tx_bit = 1 holds the current level
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (line -> J)
//   tx_bit              : data/stuff bit to encode
//   bit_strobe          : update the line this cycle
//   force_se0, force_j  : EOP line overrides (force_se0 wins)
//   d_plus, d_minus     : registered bus outputs
// ----------------------------------------------------------------------------
module usb_nrzi_encoder
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tx_bit,
    input  logic bit_strobe,
    input  logic force_se0,
    input  logic force_j,
    output logic d_plus,
    output logic d_minus
);

    logic [1:0] line_reg;
    logic [1:0] line_next;
    logic       level_reg;      // 1 = J, 0 = K
    logic       level_next;

    always_comb begin
        line_next  = line_reg;
        level_next = level_reg;
        if (bit_strobe) begin
            if (force_se0) begin
                line_next = LINE_SE0;
            end else if (force_j) begin
                level_next = 1'b1;
                line_next  = LINE_J;
            end else begin
                level_next = tx_bit ? level_reg : ~level_reg;
                line_next  = level_next ? LINE_J : LINE_K;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_reg  <= LINE_J;
            level_reg <= 1'b1;
        end else begin
            line_reg  <= line_next;
            level_reg <= level_next;
        end
    end

    assign d_plus  = line_reg[1];
    assign d_minus = line_reg[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// ----------------------------------------------------------------------------
// usb_tx_serializer
// USB full-speed transmit serializer: takes packet bytes over a valid/ready
// handshake, shifts them out LSB-first, inserts a stuff bit after every
// STUFF_LIMIT consecutive 1s, NRZI-encodes onto d_plus/d_minus and closes
// each packet with EOP (SE0, SE0, J).
// Build option: define USB_TX_SYNC_EN to send SYNC_BYTE ahead of the first
// packet byte; otherwise upstream supplies SYNC as the first byte.
// Parameters:
//   CLKS_PER_BIT : clock cycles per bus bit period (>= 2)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : byte handshake (slave side)
//   d_plus    : bus D+ (registered)
//   d_minus   : bus D- (registered)
//   tx_active : high from the first bit of a packet through the end of EOP
//   tx_err    : one-cycle pulse when the next byte is missing (underrun)
// ----------------------------------------------------------------------------
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    usb_tx_serializer_if.slave   bus,
    output logic                 d_plus,
    output logic                 d_minus,
    output logic                 tx_active,
    output logic                 tx_err
);

    localparam int            TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    ONES_LIMIT = 3'(STUFF_LIMIT);

    tx_state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [2:0]    ones_reg, ones_next;
    logic          last_reg, last_next;
    logic          se0_second_reg, se0_second_next;
    logic          active_reg, active_next;
    logic          err_reg, err_next;

    logic [7:0]    hold_data_reg;
    logic          hold_last_reg;
    logic          hold_full_reg;

    logic          expire;
    logic          strobe;
    logic          nrzi_bit;
    logic          force_se0;
    logic          force_j;
    logic          consume;
    logic          advance;

    assign expire = (timer_reg == TIMER_LAST);

    // ------------------------------------------------------------------
    // Next-state / line-update logic. Every line update (strobe) restarts
    // the bit timer, so each segment lasts exactly CLKS_PER_BIT cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_idx_next    = bit_idx_reg;
        ones_next       = ones_reg;
        last_next       = last_reg;
        se0_second_next = se0_second_reg;
        active_next     = active_reg;
        err_next        = 1'b0;
        strobe          = 1'b0;
        nrzi_bit        = 1'b0;
        force_se0       = 1'b0;
        force_j         = 1'b0;
        consume         = 1'b0;
        advance         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    state_next   = ST_SHIFT;
                    active_next  = 1'b1;
                    bit_idx_next = 3'd0;
                    strobe       = 1'b1;
`ifdef USB_TX_SYNC_EN
                    // Holding byte stays put until SYNC has been shifted out.
                    shift_next   = SYNC_BYTE;
                    last_next    = 1'b0;
                    nrzi_bit     = SYNC_BYTE[0];
`else
                    shift_next   = hold_data_reg;
                    last_next    = hold_last_reg;
                    consume      = 1'b1;
                    nrzi_bit     = hold_data_reg[0];
`endif
                    ones_next    = nrzi_bit ? 3'd1 : 3'd0;
                end
            end

            ST_SHIFT: begin
                if (expire) begin
                    if (ones_reg == ONES_LIMIT) begin
                        state_next = ST_STUFF;
                        strobe     = 1'b1;
                        nrzi_bit   = 1'b0;
                        ones_next  = 3'd0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            // The stuff bit does not move bit_idx, so the end-of-byte
            // decision after it is the one the preceding data bit deferred.
            ST_STUFF: begin
                if (expire) begin
                    advance = 1'b1;
                end
            end

            ST_EOP_SE0: begin
                if (expire) begin
                    strobe = 1'b1;
                    if (!se0_second_reg) begin
                        se0_second_next = 1'b1;
                        force_se0       = 1'b1;
                    end else begin
                        state_next = ST_EOP_J;
                        force_j    = 1'b1;
                    end
                end
            end

            ST_EOP_J: begin
                if (expire) begin
                    state_next  = ST_IDLE;
                    active_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Move to the next data bit, the next byte, or EOP.
        if (advance) begin
            strobe = 1'b1;
            if (bit_idx_reg != 3'd7) begin
                state_next   = ST_SHIFT;
                bit_idx_next = bit_idx_reg + 3'd1;
                nrzi_bit     = shift_reg[bit_idx_next];
                ones_next    = nrzi_bit ? ones_reg + 3'd1 : 3'd0;
            end else if (last_reg || !hold_full_reg) begin
                err_next        = ~last_reg;
                state_next      = ST_EOP_SE0;
                force_se0       = 1'b1;
                se0_second_next = 1'b0;
            end else begin
                state_next   = ST_SHIFT;
                shift_next   = hold_data_reg;
                last_next    = hold_last_reg;
                consume      = 1'b1;
                bit_idx_next = 3'd0;
                nrzi_bit     = hold_data_reg[0];
                ones_next    = nrzi_bit ? ones_reg + 3'd1 : 3'd0;
            end
        end

        if (strobe || expire) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            ones_reg       <= '0;
            last_reg       <= 1'b0;
            se0_second_reg <= 1'b0;
            active_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            shift_reg      <= shift_next;
            bit_idx_reg    <= bit_idx_next;
            ones_reg       <= ones_next;
            last_reg       <= last_next;
            se0_second_reg <= se0_second_next;
            active_reg     <= active_next;
            err_reg        <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Holding register. Capture and consume never coincide: capture needs
    // it empty, consume needs it full.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_reg <= '0;
            hold_last_reg <= 1'b0;
            hold_full_reg <= 1'b0;
        end else if (consume) begin
            hold_full_reg <= 1'b0;
        end else if (bus.tx_valid && !hold_full_reg) begin
            hold_data_reg <= bus.tx_data;
            hold_last_reg <= bus.tx_last;
            hold_full_reg <= 1'b1;
        end
    end

    assign bus.tx_ready = ~hold_full_reg;
    assign tx_active    = active_reg;
    assign tx_err       = err_reg;

    usb_nrzi_encoder u_nrzi (
        .clk        (clk),
        .rst        (rst),
        .tx_bit     (nrzi_bit),
        .bit_strobe (strobe),
        .force_se0  (force_se0),
        .force_j    (force_j),
        .d_plus     (d_plus),
        .d_minus    (d_minus)
    );

endmodule
